// File: rtl/vx_prefetch_tracker.sv
// rtl/vx_prefetch_tracker.sv - per-line prefetch/used metadata store with usefulness counters
// Two-stage pipeline: stage 0 reads the metadata RAM, stage 1 updates it and the statistics.
module vx_prefetch_tracker #(
    parameter int LINES       = 64,
    parameter int CTR_WIDTH   = 16,
    parameter int TRACK_READS = 1,
    localparam int ADDRW      = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDRW-1:0]     req_addr,
    input  logic                 req_fill,
    input  logic                 req_prefetch,
    input  logic                 req_rw,
    output logic                 rsp_valid,
    output logic                 rsp_prefetched,
    output logic                 rsp_used,
    output logic [CTR_WIDTH-1:0] useful_count,
    output logic [CTR_WIDTH-1:0] useless_count,
    output logic                 init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam bit TRACK_RD = (TRACK_READS != 0);

    state_t               state_q;
    state_t               state_d;
    logic [ADDRW-1:0]     sweep_q;
    logic                 accept;

    logic                 s1_valid;
    logic [ADDRW-1:0]     s1_addr;
    logic                 s1_fill;
    logic                 s1_prefetch;
    logic                 s1_rw;
    logic                 byp_hit_q;
    logic [1:0]           byp_data_q;

    logic [1:0]           mem [LINES];
    logic [1:0]           ram_q;
    logic                 ram_we;
    logic [ADDRW-1:0]     ram_waddr;
    logic [1:0]           ram_wdata;

    logic [1:0]           old_pu;
    logic                 s1_we;
    logic [1:0]           s1_wdata;
    logic                 useful_inc;
    logic                 useless_inc;

    assign accept    = req_valid & req_ready;
    assign req_ready = (state_q == ST_RUN) & ~stall;
    assign init_done = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_q == ADDRW'(LINES - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // The RAM cannot return a same-edge write, so a read issued while stage 1
    // writes the same line takes the stage-1 write data instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            byp_hit_q <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                byp_hit_q <= s1_we & (s1_addr == req_addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr     <= req_addr;
            s1_fill     <= req_fill;
            s1_prefetch <= req_prefetch;
            s1_rw       <= req_rw;
            byp_data_q  <= s1_wdata;
        end
    end

    // Reset blocks both the sweep and any in-flight stage-1 write.
    assign ram_we    = ~reset & ((state_q == ST_INIT) | s1_we);
    assign ram_waddr = (state_q == ST_INIT) ? sweep_q : s1_addr;
    assign ram_wdata = (state_q == ST_INIT) ? 2'b00 : s1_wdata;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (accept) begin
            ram_q <= mem[req_addr];
        end
    end

    assign old_pu = byp_hit_q ? byp_data_q : ram_q;

    always_comb begin
        s1_we       = 1'b0;
        s1_wdata    = old_pu;
        useful_inc  = 1'b0;
        useless_inc = 1'b0;
        if (s1_valid) begin
            if (s1_fill) begin
                s1_we       = 1'b1;
                s1_wdata    = {s1_prefetch, 1'b0};
                useless_inc = old_pu[1] & ~old_pu[0];
            end else if (!s1_prefetch && (s1_rw || TRACK_RD)) begin
                s1_we      = 1'b1;
                s1_wdata   = {old_pu[1], 1'b1};
                useful_inc = old_pu[1] & ~old_pu[0];
            end
        end
    end

    assign rsp_valid      = s1_valid;
    assign rsp_prefetched = s1_valid & old_pu[1];
    assign rsp_used       = s1_valid & old_pu[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            useful_count  <= '0;
            useless_count <= '0;
        end else begin
            if (useful_inc && (useful_count != {CTR_WIDTH{1'b1}})) begin
                useful_count <= useful_count + 1'b1;
            end
            if (useless_inc && (useless_count != {CTR_WIDTH{1'b1}})) begin
                useless_count <= useless_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_prefetch_tracker.sv
// tb/tb_vx_prefetch_tracker.sv - scoreboard bench for vx_prefetch_tracker
// dut_a: default parameters; dut_b: CTR_WIDTH=2, TRACK_READS=0.
module tb_vx_prefetch_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        stall_a = 1'b0, va = 1'b0, fill_a = 1'b0, pf_a = 1'b0, rw_a = 1'b0;
    logic [5:0]  addr_a = '0;
    logic        req_ready_a, rsp_valid_a, rsp_p_a, rsp_u_a, init_done_a;
    logic [15:0] useful_a, useless_a;

    logic        stall_b = 1'b0, vb = 1'b0, fill_b = 1'b0, pf_b = 1'b0, rw_b = 1'b0;
    logic [5:0]  addr_b = '0;
    logic        req_ready_b, rsp_valid_b, rsp_p_b, rsp_u_b, init_done_b;
    logic [1:0]  useful_b, useless_b;

    int tests = 0;
    int fails = 0;
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    always #5 clk = ~clk;

    vx_prefetch_tracker #(.LINES(64), .CTR_WIDTH(16), .TRACK_READS(1)) dut_a (
        .clk(clk), .reset(reset), .stall(stall_a), .req_valid(va), .req_ready(req_ready_a),
        .req_addr(addr_a), .req_fill(fill_a), .req_prefetch(pf_a), .req_rw(rw_a),
        .rsp_valid(rsp_valid_a), .rsp_prefetched(rsp_p_a), .rsp_used(rsp_u_a),
        .useful_count(useful_a), .useless_count(useless_a), .init_done(init_done_a)
    );

    vx_prefetch_tracker #(.LINES(64), .CTR_WIDTH(2), .TRACK_READS(0)) dut_b (
        .clk(clk), .reset(reset), .stall(stall_b), .req_valid(vb), .req_ready(req_ready_b),
        .req_addr(addr_b), .req_fill(fill_b), .req_prefetch(pf_b), .req_rw(rw_b),
        .rsp_valid(rsp_valid_b), .rsp_prefetched(rsp_p_b), .rsp_used(rsp_u_b),
        .useful_count(useful_b), .useless_count(useless_b), .init_done(init_done_b)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_a_unexpected: got rsp {%0d,%0d}, expected none", rsp_p_a, rsp_u_a);
            end else begin
                check("rsp_a", int'({rsp_p_a, rsp_u_a}), int'(q_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid_b) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_b_unexpected: got rsp {%0d,%0d}, expected none", rsp_p_b, rsp_u_b);
            end else begin
                check("rsp_b", int'({rsp_p_b, rsp_u_b}), int'(q_b.pop_front()));
            end
        end
    end

    // Holds the request until accepted; returns 1 time unit after the accept edge.
    task automatic issue(input bit b, input int addr, input bit fill, input bit pf,
                         input bit rw, input bit ep, input bit eu);
        bit rdy;
        int tries;
        rdy = 1'b0;
        tries = 0;
        if (b) begin
            vb = 1'b1; addr_b = 6'(addr); fill_b = fill; pf_b = pf; rw_b = rw;
        end else begin
            va = 1'b1; addr_a = 6'(addr); fill_a = fill; pf_a = pf; rw_a = rw;
        end
        while (!rdy && tries < 200) begin
            @(negedge clk);
            rdy = b ? req_ready_b : req_ready_a;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept, expected accept of line %0d", addr);
        end else if (b) begin
            q_b.push_back({ep, eu});
        end else begin
            q_a.push_back({ep, eu});
        end
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int cnt;
        bit early;
        cnt = 0;
        early = 1'b0;
        while (cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (init_done_a) break;
            if (req_ready_a || req_ready_b) early = 1'b1;
        end
        check("init_cycles", cnt, 64);
        check("ready_before_init", int'(early), 0);
        check("init_done_b", int'(init_done_b), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready_a), 0);
        check("rst_rsp_valid", int'(rsp_valid_a), 0);
        check("rst_rsp_bits", int'({rsp_p_a, rsp_u_a}), 0);
        check("rst_useful", int'(useful_a), 0);
        check("rst_useless", int'(useless_a), 0);
        check("rst_init_done", int'(init_done_a), 0);
        reset = 1'b0;
        wait_init();

        // Every line reads back cleared; TRACK_READS=1 sets U on each.
        for (int i = 0; i < 64; i++) issue(0, i, 0, 0, 0, 0, 0);
        idle(2);
        check("cnt_after_sweep", int'(useful_a) + int'(useless_a), 0);

        issue(0, 5, 1, 1, 0, 0, 1);
        idle(2);
        issue(0, 5, 0, 0, 0, 1, 0);
        issue(0, 5, 0, 0, 0, 1, 1);
        idle(2);
        check("useful_line5", int'(useful_a), 1);

        issue(0, 9, 1, 1, 0, 0, 1);
        issue(0, 9, 1, 0, 0, 1, 0);
        idle(2);
        issue(0, 9, 0, 0, 0, 0, 0);
        idle(2);
        check("useless_line9", int'(useless_a), 1);
        check("useful_line9", int'(useful_a), 1);

        issue(0, 3, 1, 1, 0, 0, 1);
        issue(0, 3, 0, 0, 1, 1, 0);
        issue(0, 3, 0, 0, 0, 1, 1);
        idle(2);
        check("useful_bypass", int'(useful_a), 2);

        issue(0, 7, 1, 1, 0, 0, 1);
        idle(2);
        issue(0, 7, 0, 1, 0, 1, 0);
        idle(2);
        issue(0, 7, 0, 0, 0, 1, 0);
        idle(2);
        check("useful_pf_hit", int'(useful_a), 3);
        check("useless_pf_hit", int'(useless_a), 1);

        stall_a = 1'b1;
        va = 1'b1; addr_a = 6'd1; fill_a = 1'b0; pf_a = 1'b0; rw_a = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_ready", int'(req_ready_a), 0);
            check("stall_rsp_valid", int'(rsp_valid_a), 0);
        end
        va = 1'b0;
        stall_a = 1'b0;
        idle(2);

        // TRACK_READS=0: a demand read leaves the line untouched.
        issue(1, 3, 1, 1, 0, 0, 0);
        issue(1, 3, 0, 0, 0, 1, 0);
        idle(2);
        issue(1, 3, 0, 0, 0, 1, 0);
        idle(2);
        check("b_useful_read", int'(useful_b), 0);

        for (int k = 0; k < 4; k++) begin
            issue(1, 10 + k, 1, 1, 0, 0, 0);
            issue(1, 10 + k, 0, 0, 1, 1, 0);
        end
        idle(2);
        check("b_useful_sat", int'(useful_b), 3);

        issue(1, 3, 0, 1, 0, 1, 0);
        idle(2);
        issue(1, 3, 0, 0, 0, 1, 0);
        idle(2);
        check("b_useful_pf_hit", int'(useful_b), 3);
        check("b_useless_pf_hit", int'(useless_b), 0);

        // Reset lands on the stage-1 cycle of a useless-prefetch replacement.
        issue(0, 20, 1, 1, 0, 0, 1);
        idle(2);
        issue(0, 20, 1, 0, 0, 1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_useless", int'(useless_a), 0);
        check("midrst_useful", int'(useful_a), 0);
        check("midrst_init_done", int'(init_done_a), 0);
        idle(2);
        reset = 1'b0;
        wait_init();
        check("post_useless", int'(useless_a), 0);
        check("post_useful", int'(useful_a), 0);
        issue(0, 20, 0, 0, 0, 0, 0);
        idle(4);
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
